// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin with a lock override.
// Each access runs IDLE -> BUSY -> DONE, so at most one access completes every three cycles.
module mem_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_0,
    input  logic        we_0,
    input  logic        lock_0,
    input  logic [31:0] addr_0,
    input  logic [31:0] wdata_0,
    input  logic        req_1,
    input  logic        we_1,
    input  logic        lock_1,
    input  logic [31:0] addr_1,
    input  logic [31:0] wdata_1,
    output logic        gnt_0,
    output logic        done_0,
    output logic [31:0] rdata_0,
    output logic        gnt_1,
    output logic        done_1,
    output logic [31:0] rdata_1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    output logic        mem_we,
    input  logic [31:0] mem_data_in
);

    typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StDone = 2'd2} state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        lock_valid_q, lock_valid_d;
    logic        lock_owner_q, lock_owner_d;
    logic        winner_q, winner_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_data_out_q, mem_data_out_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  eligible;
    logic        lock_held;
    logic        winner;
    logic        accept;

    // A lock only counts while its owner still drives lock high; dropping it frees the arbiter
    // in the same cycle.
    always_comb begin
        req       = {req_1, req_0};
        lock      = {lock_1, lock_0};
        lock_held = lock_valid_q & lock[lock_owner_q];
        eligible  = req;
        if (lock_held) begin
            eligible = lock_owner_q ? (req & 2'b10) : (req & 2'b01);
        end
        winner = (eligible == 2'b11) ? ~ptr_q : eligible[1];
        accept = (state_q == StIdle) && (eligible != 2'b00);
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        lock_valid_d   = lock_valid_q;
        lock_owner_d   = lock_owner_q;
        winner_d       = winner_q;
        mem_address_d  = mem_address_q;
        mem_data_out_d = mem_data_out_q;
        mem_we_d       = mem_we_q;
        rdata0_d       = rdata0_q;
        rdata1_d       = rdata1_q;
        case (state_q)
            StIdle: begin
                lock_valid_d = lock_held;
                if (accept) begin
                    state_d        = StBusy;
                    winner_d       = winner;
                    ptr_d          = winner;
                    lock_valid_d   = lock[winner];
                    lock_owner_d   = winner;
                    mem_address_d  = winner ? addr_1 : addr_0;
                    mem_data_out_d = winner ? wdata_1 : wdata_0;
                    mem_we_d       = winner ? we_1 : we_0;
                end
            end
            StBusy: begin
                state_d  = StDone;
                mem_we_d = 1'b0;
                if (!mem_we_q) begin
                    if (winner_q) rdata1_d = mem_data_in;
                    else          rdata0_d = mem_data_in;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (lock_valid_q && !lock[lock_owner_q]) begin
                    lock_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= StIdle;
            ptr_q          <= 1'b1;
            lock_valid_q   <= 1'b0;
            lock_owner_q   <= 1'b0;
            winner_q       <= 1'b0;
            mem_address_q  <= '0;
            mem_data_out_q <= '0;
            mem_we_q       <= 1'b0;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            lock_valid_q   <= lock_valid_d;
            lock_owner_q   <= lock_owner_d;
            winner_q       <= winner_d;
            mem_address_q  <= mem_address_d;
            mem_data_out_q <= mem_data_out_d;
            mem_we_q       <= mem_we_d;
            rdata0_q       <= rdata0_d;
            rdata1_q       <= rdata1_d;
        end
    end

    // Handshakes are masked during reset so an aborted access never signals grant or completion.
    assign gnt_0  = resetn & accept & ~winner;
    assign gnt_1  = resetn & accept & winner;
    assign done_0 = resetn & (state_q == StDone) & ~winner_q;
    assign done_1 = resetn & (state_q == StDone) & winner_q;

    assign rdata_0      = rdata0_q;
    assign rdata_1      = rdata1_q;
    assign mem_address  = mem_address_q;
    assign mem_data_out = mem_data_out_q;
    assign mem_we       = mem_we_q;

endmodule
